// File: rtl/read_burst_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// read_burst_req_ctrl_if
//   AXI read address (AR) and read data (R) handshake signals used by the VDMA
//   read burst request generator. Only the control fields are carried here.
//   R data flows directly to the read FIFO and does not pass through this block.
//
//   Valid/ready semantics: a transfer happens on a rising clock edge where both
//   valid and ready are 1. Once the master raises arvalid, it holds arvalid,
//   araddr and arlen stable until that edge.
//
//   Signals
//     arvalid  master->slave  AR request valid
//     araddr   master->slave  AR byte address (ASIZE bits)
//     arlen    master->slave  AR beats-1
//     arready  slave->master  AR accept
//     rvalid   slave->master  R beat valid
//     rlast    slave->master  R last beat of burst
//     rready   master->slave  R accept
// -----------------------------------------------------------------------------
interface read_burst_req_ctrl_if #(
  parameter int ASIZE = 32
);
  logic             arvalid;
  logic [ASIZE-1:0] araddr;
  logic [7:0]       arlen;
  logic             arready;
  logic             rvalid;
  logic             rlast;
  logic             rready;

  modport master (
    output arvalid, araddr, arlen, rready,
    input  arready, rvalid, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    output arready, rvalid, rlast
  );
endinterface

// File: rtl/read_burst_req_ctrl.sv
// -----------------------------------------------------------------------------
// read_burst_req_ctrl
//   Read-side AXI burst request generator for the VDMA read channel. For each
//   frame it issues AR bursts of NOR_BURST_LEN beats, followed by one shorter
//   tail burst, starting at a base address. It counts the returning R beats.
//   When a burst completes, it pulses burst_done_o or tail_done_o back to the
//   line-length status stage. That stage answers with tail_status_i and
//   tail_len_i.
//
//   Ports
//     clock, rst        single clock; synchronous active-high reset
//     fsync_i           frame start pulse; baseaddr_i is latched with it
//     baseaddr_i        frame base byte address
//     fifo_afull_i      read FIFO almost full; holds off new AR issue only
//     tail_status_i     status stage: the next burst is the tail
//     tail_len_i        tail burst length in beats
//     axi               AR/R handshake (master modport)
//     burst_done_o      1-cycle pulse when a normal burst has been received
//     tail_done_o       1-cycle pulse when the tail burst has been received
//     frame_done_o      1-cycle pulse, one cycle after tail_done_o
//     busy_o            high in every state except IDLE
//     beat_err_o        sticky flag: rlast arrived at the wrong beat
//     state_o           current FSM state, for debug
//
//   Valid/ready semantics: arvalid is held together with a stable
//   araddr/arlen until the edge where arready is also 1. An R beat is
//   counted on any edge where rvalid and rready are both 1.
//   arvalid (ADDR state) and rready (DATA state) are never 1 at the same time.
// -----------------------------------------------------------------------------
module read_burst_req_ctrl #(
  parameter int NOR_BURST_LEN = 200,
  parameter int AXI_DSIZE     = 256,
  parameter int ASIZE         = 32,
  parameter int LSIZE         = 9,
  parameter int SETTLE        = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  fsync_i,
  input  logic [ASIZE-1:0]      baseaddr_i,
  input  logic                  fifo_afull_i,
  input  logic                  tail_status_i,
  input  logic [LSIZE-1:0]      tail_len_i,
  read_burst_req_ctrl_if.master axi,
  output logic                  burst_done_o,
  output logic                  tail_done_o,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  beat_err_o,
  output logic [2:0]            state_o
);

  localparam int BYTES_PER_BEAT = AXI_DSIZE / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DECIDE = 3'd2,
    S_ADDR   = 3'd3,
    S_DATA   = 3'd4,
    S_DONE   = 3'd5,
    S_FEND   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  // One counter serves two uses: it counts settle cycles in SETTLE and
  // received beats in DATA. It is cleared when either phase is entered.
  logic [8:0]       cnt_q, cnt_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [ASIZE-1:0] base_q, base_d;
  logic [8:0]       len_q, len_d;
  logic             is_tail_q, is_tail_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [ASIZE-1:0] step;

  assign step = ASIZE'(len_q) * ASIZE'(BYTES_PER_BEAT);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      is_tail_q <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      len_q     <= len_d;
      is_tail_q <= is_tail_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    base_d       = base_q;
    len_d        = len_q;
    is_tail_d    = is_tail_q;
    pend_d       = pend_q;
    err_d        = err_q;
    axi.arvalid  = 1'b0;
    axi.araddr   = '0;
    axi.arlen    = '0;
    axi.rready   = 1'b0;
    burst_done_o = 1'b0;
    tail_done_o  = 1'b0;
    frame_done_o = 1'b0;

    // fsync always captures the new base address and clears the error
    // flag. Whether it also restarts the frame immediately depends on
    // the current state.
    if (fsync_i) begin
      base_d = baseaddr_i;
      err_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (fsync_i) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          addr_d  = baseaddr_i;
        end
      end

      S_SETTLE: begin
        if (fsync_i) begin
          cnt_d  = '0;
          addr_d = baseaddr_i;
        end else if (cnt_q == 9'(SETTLE - 1)) begin
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_DECIDE: begin
        if (fsync_i) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          addr_d  = baseaddr_i;
        end else begin
          // The status stage is sampled here, and only here. The sample
          // is retaken on every cycle that the FIFO holds us in DECIDE.
          len_d     = tail_status_i ? 9'(tail_len_i) : 9'(NOR_BURST_LEN);
          is_tail_d = tail_status_i;
          if (!fifo_afull_i) state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        axi.arvalid = 1'b1;
        axi.araddr  = addr_q;
        axi.arlen   = 8'(len_q - 9'd1);
        if (fsync_i) pend_d = 1'b1;
        if (axi.arready) begin
          addr_d  = addr_q + step;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        axi.rready = 1'b1;
        if (fsync_i) pend_d = 1'b1;
        if (axi.rvalid) begin
          if (axi.rlast) begin
            // A burst always ends on rlast. The flag records when rlast
            // arrived at a beat other than the one requested.
            if (cnt_q != len_q - 9'd1) err_d = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end

      S_DONE: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
        if (pend_q || fsync_i) begin
          // A frame restart arrived during this burst. The drained burst
          // is not reported, and the new frame starts from the captured
          // base address.
          addr_d = base_d;
          pend_d = 1'b0;
        end else if (is_tail_q) begin
          tail_done_o = 1'b1;
          state_d     = S_FEND;
        end else begin
          burst_done_o = 1'b1;
        end
      end

      S_FEND: begin
        frame_done_o = 1'b1;
        if (fsync_i) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          addr_d  = baseaddr_i;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE);
  assign beat_err_o = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_read_burst_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_read_burst_req_ctrl
//   Directed bench for read_burst_req_ctrl. Settings: NOR_BURST_LEN=16,
//   AXI_DSIZE=256 (32 bytes per beat), SETTLE=4, 40-beat frames.
//   The status stage is modelled by a count of remaining beats. The tail is
//   signalled once 16 or fewer beats remain.
//   Inputs are driven, and outputs sampled, on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_read_burst_req_ctrl;

  logic        clock;
  logic        rst;
  logic        fsync;
  logic [31:0] baseaddr;
  logic        fifo_afull;
  logic        tail_status;
  logic [8:0]  tail_len;
  logic        burst_done, tail_done, frame_done, busy, beat_err;
  logic [2:0]  state;

  int remaining;
  int n_checks;
  int n_errors;

  read_burst_req_ctrl_if #(.ASIZE(32)) axi_if ();

  read_burst_req_ctrl #(
    .NOR_BURST_LEN(16),
    .AXI_DSIZE    (256),
    .ASIZE        (32),
    .LSIZE        (9),
    .SETTLE       (4)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .fsync_i      (fsync),
    .baseaddr_i   (baseaddr),
    .fifo_afull_i (fifo_afull),
    .tail_status_i(tail_status),
    .tail_len_i   (tail_len),
    .axi          (axi_if),
    .burst_done_o (burst_done),
    .tail_done_o  (tail_done),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .beat_err_o   (beat_err),
    .state_o      (state)
  );

  // status stage model
  assign tail_status = (remaining <= 16);
  assign tail_len    = 9'(remaining);

  // clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [31:0] base);
    baseaddr  = base;
    fsync     = 1'b1;
    remaining = 40;
    @(negedge clock);
    fsync = 1'b0;
  endtask

  // Count falling edges until arvalid is seen. The wait is bounded.
  task automatic wait_ar(input string tag, input int exp_wait);
    int w;
    w = 0;
    while (axi_if.arvalid !== 1'b1 && w < 200) begin
      @(negedge clock);
      w++;
    end
    chk(tag, w, exp_wait);
  endtask

  // Serve one burst.
  // kind: 0 = expect burst_done, 1 = expect tail_done, 2 = expect no pulse.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [7:0] exp_len,
                       input int stall, input int nbeats, input int sync_beat,
                       input logic [31:0] sync_base, input int kind);
    chk({tag, "_arvalid"}, axi_if.arvalid, 1'b1);
    chk({tag, "_araddr"}, axi_if.araddr, exp_addr);
    chk({tag, "_arlen"}, axi_if.arlen, exp_len);
    chk({tag, "_rready_excl"}, axi_if.rready, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      chk({tag, "_stall_arvalid"}, axi_if.arvalid, 1'b1);
      chk({tag, "_stall_araddr"}, axi_if.araddr, exp_addr);
      chk({tag, "_stall_arlen"}, axi_if.arlen, exp_len);
    end
    axi_if.arready = 1'b1;
    @(negedge clock);
    axi_if.arready = 1'b0;
    chk({tag, "_single_hs"}, axi_if.arvalid, 1'b0);
    chk({tag, "_rready"}, axi_if.rready, 1'b1);
    for (int b = 0; b < nbeats; b++) begin
      if (b == sync_beat) begin
        fsync     = 1'b1;
        baseaddr  = sync_base;
        remaining = 40;
      end
      axi_if.rvalid = 1'b1;
      axi_if.rlast  = (b == nbeats - 1);
      @(negedge clock);
      fsync         = 1'b0;
      axi_if.rvalid = 1'b0;
      axi_if.rlast  = 1'b0;
    end
    chk({tag, "_burst_done"}, burst_done, (kind == 0) ? 32'd1 : 32'd0);
    chk({tag, "_tail_done"}, tail_done, (kind == 1) ? 32'd1 : 32'd0);
    if (kind == 0) remaining -= 16;
    if (kind == 1) begin
      @(negedge clock);
      chk({tag, "_frame_done"}, frame_done, 1'b1);
      chk({tag, "_fend_busy"}, busy, 1'b1);
      @(negedge clock);
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_idle_frame_done"}, frame_done, 1'b0);
    end
  endtask

  // Remaining two bursts of a 40-beat frame, at base+0x200 and base+0x400.
  task automatic finish_frame(input string tag, input logic [31:0] base);
    wait_ar({tag, "_lat2"}, 6);
    serve({tag, "_b2"}, base + 32'h200, 8'd15, 0, 16, -1, 32'h0, 0);
    wait_ar({tag, "_lat3"}, 6);
    serve({tag, "_b3"}, base + 32'h400, 8'd7, 0, 8, -1, 32'h0, 1);
  endtask

  initial begin
    int seen;
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    fsync          = 1'b0;
    baseaddr       = 32'h0;
    fifo_afull     = 1'b0;
    remaining      = 40;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rlast   = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_arvalid", axi_if.arvalid, 1'b0);
    chk("rst_rready", axi_if.rready, 1'b0);
    chk("rst_araddr", axi_if.araddr, 32'h0);
    chk("rst_arlen", axi_if.arlen, 8'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_beat_err", beat_err, 1'b0);
    chk("rst_done", {burst_done, tail_done, frame_done}, 3'b000);
    chk("rst_state", state, 3'd0);
    rst = 1'b0;
    @(negedge clock);

    // 1: normal frame
    start_frame(32'h1000);
    chk("t1_busy", busy, 1'b1);
    wait_ar("t1_lat1", 5);
    serve("t1_b1", 32'h1000, 8'd15, 0, 16, -1, 32'h0, 0);
    finish_frame("t1", 32'h1000);
    chk("t1_beat_err", beat_err, 1'b0);

    // 2: arready stalled 5 cycles on the first AR
    start_frame(32'h1000);
    wait_ar("t2_lat1", 5);
    serve("t2_b1", 32'h1000, 8'd15, 5, 16, -1, 32'h0, 0);
    finish_frame("t2", 32'h1000);

    // 3: FIFO almost-full holds off AR issue
    fifo_afull = 1'b1;
    start_frame(32'h3000);
    seen = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      if (axi_if.arvalid === 1'b1) seen++;
    end
    chk("t3_no_arvalid", seen, 0);
    chk("t3_in_decide", state, 3'd2);
    fifo_afull = 1'b0;
    wait_ar("t3_lat_afull", 1);
    serve("t3_b1", 32'h3000, 8'd15, 0, 16, -1, 32'h0, 0);
    finish_frame("t3", 32'h3000);

    // 4: fsync in the middle of the second burst
    start_frame(32'h1000);
    wait_ar("t4_lat1", 5);
    serve("t4_b1", 32'h1000, 8'd15, 0, 16, -1, 32'h0, 0);
    wait_ar("t4_lat2", 6);
    serve("t4_b2", 32'h1200, 8'd15, 0, 16, 5, 32'h8000, 2);
    wait_ar("t4_lat_restart", 6);
    serve("t4_n1", 32'h8000, 8'd15, 0, 16, -1, 32'h0, 0);
    finish_frame("t4n", 32'h8000);

    // 5: early rlast sets a sticky beat_err
    start_frame(32'h1000);
    wait_ar("t5_lat1", 5);
    serve("t5_b1", 32'h1000, 8'd15, 0, 10, -1, 32'h0, 0);
    chk("t5_err_set", beat_err, 1'b1);
    wait_ar("t5_lat2", 6);
    serve("t5_b2", 32'h1200, 8'd15, 0, 16, -1, 32'h0, 0);
    chk("t5_err_sticky", beat_err, 1'b1);
    wait_ar("t5_lat3", 6);
    serve("t5_b3", 32'h1400, 8'd7, 0, 8, -1, 32'h0, 1);
    chk("t5_err_sticky2", beat_err, 1'b1);
    start_frame(32'h5000);
    chk("t5_err_cleared", beat_err, 1'b0);

    // 6: reset in DATA, then a fresh frame
    wait_ar("t6_lat1", 5);
    chk("t6_araddr", axi_if.araddr, 32'h5000);
    axi_if.arready = 1'b1;
    @(negedge clock);
    axi_if.arready = 1'b0;
    chk("t6_in_data", state, 3'd4);
    for (int b = 0; b < 3; b++) begin
      axi_if.rvalid = 1'b1;
      @(negedge clock);
    end
    axi_if.rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clock);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rready", axi_if.rready, 1'b0);
    chk("t6_rst_arvalid", axi_if.arvalid, 1'b0);
    chk("t6_rst_state", state, 3'd0);
    chk("t6_rst_done", {burst_done, tail_done, frame_done, beat_err}, 4'b0000);
    rst = 1'b0;
    @(negedge clock);
    start_frame(32'h2000);
    wait_ar("t6_lat_fresh", 5);
    serve("t6_b1", 32'h2000, 8'd15, 0, 16, -1, 32'h0, 0);
    finish_frame("t6", 32'h2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
